// File: rtl/serial_alu_accum.sv
// serial_alu_accum: bit-serial ALU and accumulator. It drives the serial
// register file's shift, produces one result bit per cycle and writes the
// parallel result back through the register file's store port.
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   start, op      operation request and opcode, sampled only while idle
//   wb_en          write-back enable, sampled together with start
//   rs1_bit        rs1 operand bit, LSB first
//   rs2_bit        rs2 operand bit, LSB first
//   reg_shift_en   advance the register file bit index
//   reg_store_en   parallel store of result into the register file
//   result         accumulator, feeds the register file parallel input
//   busy           operation in progress
//   done           one-cycle completion pulse
//   carry_flag     final carry of the last ADD/SUB
//   zero_flag      last result was zero
module serial_alu_accum #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             wb_en,
  input  logic             rs1_bit,
  input  logic             rs2_bit,
  output logic             reg_shift_en,
  output logic             reg_store_en,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SLL1 = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              wb_q, wb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              prev_q, prev_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              shift_en_q, shift_en_d;
  logic              store_en_q, store_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cflag_q, cflag_d;
  logic              zflag_q, zflag_d;

  logic              b_eff_c;
  logic              bit_r_c;
  logic              carry_nxt_c;
  logic [WIDTH-1:0]  acc_nxt_c;
  logic              last_c;

  // One result bit per cycle; SUB adds the inverted rs2 with carry-in 1.
  always_comb begin
    b_eff_c     = (op_q == OP_SUB) ? ~rs2_bit : rs2_bit;
    carry_nxt_c = (rs1_bit & b_eff_c) | (rs1_bit & carry_q) | (b_eff_c & carry_q);
    bit_r_c     = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: bit_r_c = rs1_bit ^ b_eff_c ^ carry_q;
      OP_AND:         bit_r_c = rs1_bit & rs2_bit;
      OP_OR:          bit_r_c = rs1_bit | rs2_bit;
      OP_XOR:         bit_r_c = rs1_bit ^ rs2_bit;
      OP_MOV:         bit_r_c = rs2_bit;
      OP_SLL1:        bit_r_c = prev_q;
      default:        bit_r_c = rs1_bit;
    endcase
    acc_nxt_c = {bit_r_c, result_q[WIDTH-1:1]};
    last_c    = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_d       = wb_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    prev_d     = prev_q;
    result_d   = result_q;
    shift_en_d = 1'b0;
    store_en_d = 1'b0;
    done_d     = 1'b0;
    cflag_d    = cflag_q;
    zflag_d    = zflag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          wb_d       = wb_en;
          cnt_d      = '0;
          carry_d    = (op == OP_SUB);
          prev_d     = 1'b0;
          state_d    = SHIFT;
          shift_en_d = 1'b1;
        end
      end
      SHIFT: begin
        result_d = acc_nxt_c;
        carry_d  = carry_nxt_c;
        prev_d   = rs1_bit;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          // Flags land together with done, from the fully assembled result.
          done_d  = 1'b1;
          zflag_d = (acc_nxt_c == '0);
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) cflag_d = carry_nxt_c;
          if (wb_q) begin
            state_d    = STORE;
            store_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_en_d = 1'b1;
        end
      end
      STORE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wb_q       <= 1'b0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      prev_q     <= 1'b0;
      result_q   <= '0;
      shift_en_q <= 1'b0;
      store_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cflag_q    <= 1'b0;
      zflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wb_q       <= wb_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      prev_q     <= prev_d;
      result_q   <= result_d;
      shift_en_q <= shift_en_d;
      store_en_q <= store_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cflag_q    <= cflag_d;
      zflag_q    <= zflag_d;
    end
  end

  assign reg_shift_en = shift_en_q;
  assign reg_store_en = store_en_q;
  assign result       = result_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign carry_flag   = cflag_q;
  assign zero_flag    = zflag_q;

endmodule

// File: tb/tb_serial_alu_accum.sv
// Bench for serial_alu_accum: a small serial register file model feeds the
// operand bits; directed vectors plus hand-written glitch and reset sequences.
module tb_serial_alu_accum;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic         wb_en = 1'b0;
  logic         rs1_bit;
  logic         rs2_bit;
  logic         reg_shift_en;
  logic         reg_store_en;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         carry_flag;
  logic         zero_flag;

  logic [2:0]   idx;
  logic [W-1:0] rs1_val = '0;
  logic [W-1:0] rs2_val = '0;
  logic [W-1:0] rd_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_alu_accum #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .op           (op),
    .wb_en        (wb_en),
    .rs1_bit      (rs1_bit),
    .rs2_bit      (rs2_bit),
    .reg_shift_en (reg_shift_en),
    .reg_store_en (reg_store_en),
    .result       (result),
    .busy         (busy),
    .done         (done),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag)
  );

  // Serial register file model: bit index advances on each shift, store captures result.
  assign rs1_bit = rs1_val[idx];
  assign rs2_bit = rs2_val[idx];

  always @(posedge clk) begin
    if (!rstn) idx <= 3'd0;
    else if (reg_shift_en) idx <= idx + 3'd1;
  end

  always @(posedge clk) begin
    if (!rstn) rd_val <= '0;
    else if (reg_store_en) rd_val <= result;
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wb;
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation once idle; watch it through to done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic wb, input int glitch,
                        output int shifts, output int stores, output int done_cyc,
                        output int overlap, output logic [W-1:0] res_at_done,
                        output logic busy_at_done);
    int w;
    w = 0;
    while (busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_wait_timeout", 32'(busy), 32'd0);
    rs1_val = a;
    rs2_val = b;
    op      = o;
    wb_en   = wb;
    start   = 1'b1;
    shifts = 0; stores = 0; done_cyc = -1; overlap = 0;
    res_at_done = '0; busy_at_done = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = (glitch != 0) && (cyc == glitch);
      if (reg_shift_en) shifts++;
      if (reg_store_en) stores++;
      if (reg_shift_en && reg_store_en) overlap++;
      if (done) begin
        done_cyc     = cyc;
        res_at_done  = result;
        busy_at_done = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int shifts, stores, done_cyc, overlap, cnt;
    logic [W-1:0] res;
    logic bsy;
    string tag;

    vecs[0]  = '{3'b000, 8'h5A, 8'h3C, 1'b1, 8'h96, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{3'b001, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 8'h81, 8'h0F, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 8'h81, 8'h0F, 1'b1, 8'h8F, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 8'h81, 8'h0F, 1'b1, 8'h8E, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 8'h81, 8'h0F, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 8'h81, 8'h0F, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{3'b010, 8'h81, 8'h0F, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 8'h81, 8'h0F, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[12] = '{3'b100, 8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[13] = '{3'b001, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[14] = '{3'b110, 8'hC3, 8'h00, 1'b1, 8'h86, 1'b0, 1'b0};
    vecs[15] = '{3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_shift", 32'(reg_shift_en), 32'h0);
    check("rst_store", 32'(reg_store_en), 32'h0);
    check("rst_flags", {30'd0, carry_flag, zero_flag}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Vector table; vector 16 starts in the done cycle of the no-write-back vector 15
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wb, 0,
             shifts, stores, done_cyc, overlap, res, bsy);
      tag = $sformatf("v%0d", i);
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'd9);
      check({tag, "_result"}, 32'(res), 32'(vecs[i].r));
      check({tag, "_carry"}, 32'(carry_flag), 32'(vecs[i].c));
      check({tag, "_zero"}, 32'(zero_flag), 32'(vecs[i].z));
      check({tag, "_shifts"}, 32'(shifts), 32'd8);
      check({tag, "_stores"}, 32'(stores), 32'(vecs[i].wb));
      check({tag, "_overlap"}, 32'(overlap), 32'd0);
      check({tag, "_busy_at_done"}, 32'(bsy), 32'(vecs[i].wb));
      if (vecs[i].wb) begin
        @(negedge clk);
        check({tag, "_rf_written"}, 32'(rd_val), 32'(vecs[i].r));
        check({tag, "_result_held"}, 32'(result), 32'(vecs[i].r));
      end
    end

    // start pulsed again during shift cycle 3 is ignored
    run_op(3'b000, 8'h12, 8'h34, 1'b1, 3, shifts, stores, done_cyc, overlap, res, bsy);
    check("glitch_done_cycle", 32'(done_cyc), 32'd9);
    check("glitch_result", 32'(res), 32'h46);
    check("glitch_shifts", 32'(shifts), 32'd8);
    check("glitch_stores", 32'(stores), 32'd1);
    @(negedge clk);
    check("glitch_busy_fell", 32'(busy), 32'd0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (reg_shift_en || reg_store_en || done || busy) cnt++;
    end
    check("glitch_no_second_op", 32'(cnt), 32'd0);

    // Set carry/zero flags, then abort an operation with reset in shift cycle 4
    run_op(3'b000, 8'hFF, 8'h01, 1'b1, 0, shifts, stores, done_cyc, overlap, res, bsy);
    check("pre_rst_flags", {30'd0, carry_flag, zero_flag}, 32'h3);
    @(negedge clk);
    rs1_val = 8'hF0; rs2_val = 8'h0F; op = 3'b000; wb_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_shift", 32'(reg_shift_en), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_store", 32'(reg_store_en), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", {30'd0, carry_flag, zero_flag}, 32'h0);
    rstn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (reg_shift_en || reg_store_en || done) cnt++;
    end
    check("abort_quiet", 32'(cnt), 32'd0);

    // Recovery after abort stays bit-aligned
    run_op(3'b001, 8'h40, 8'h01, 1'b1, 0, shifts, stores, done_cyc, overlap, res, bsy);
    check("recover_result", 32'(res), 32'h3F);
    check("recover_carry", 32'(carry_flag), 32'd1);
    check("recover_done_cycle", 32'(done_cyc), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
